// File: rtl/if_prefetch.sv
// Instruction-fetch front end: a sequential req/ack fetcher feeding a DEPTH-entry
// prefetch queue that presents {inst, pc+4} to decode and flushes on a taken jump.
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_nx;
    logic [31:0]   pc, pc_nx;
    logic [31:0]   addr_nx;
    logic          req_nx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_after;
    logic          push, pop, credit;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc4_q  [DEPTH];

    assign id_valid    = (count != '0);
    assign pop         = id_valid && !hold && !redirect;
    assign push        = (state == WAIT) && imem_ack && !redirect;
    assign count_after = count + CW'(push) - CW'(pop);
    // A new request is allowed only if the queue can still absorb its response.
    assign credit      = (count_after < CW'(DEPTH));

    // NOTE: queue storage is never reset; gating with id_valid gives the zero reset values.
    assign id_inst = id_valid ? inst_q[rd_ptr] : '0;
    assign id_pc4  = id_valid ? pc4_q[rd_ptr]  : '0;

    always_comb begin
        // NOTE: every variable takes its held value first, so no path can infer a latch.
        state_nx = state;
        pc_nx    = pc;
        req_nx   = imem_req;
        addr_nx  = imem_addr;
        if (redirect) begin
            pc_nx = redirect_pc;
            unique case (state)
                IDLE: ;
                WAIT, DROP: begin
                    if (imem_ack) begin
                        req_nx   = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = DROP;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (credit) begin
                        req_nx   = 1'b1;
                        addr_nx  = pc;
                        state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        pc_nx = pc + 32'd4;
                        if (credit) begin
                            addr_nx = pc + 32'd4;
                        end else begin
                            req_nx   = 1'b0;
                            state_nx = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        req_nx   = 1'b0;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers use nonblocking assignments so all update on the same edge.
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc4_q[wr_ptr]  <= imem_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: latency-configurable memory model returning the
// fetch address as data, with hand-computed expectations for each scenario.
module tb_if_prefetch;
    localparam int DEPTH = 4;
    localparam logic [31:0] WRAP_A [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    localparam logic [31:0] WRAP_P [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    logic        clk = 1'b0;
    logic        rst, redirect, hold, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        id_valid, imem_req;
    logic [31:0] id_inst, id_pc4, imem_addr;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 0;
    int wcnt     = 0;
    int n_acks   = 0;
    bit proto_err = 1'b0;
    bit overflow  = 1'b0;

    always #5 clk = ~clk;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .hold       (hold),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata)
    );

    // Memory model: acks `lat` cycles after the request becomes visible, data = address.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr;
                wcnt       = 0;
                n_acks++;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    always @(posedge clk) begin
        if (imem_ack && !imem_req) proto_err = 1'b1;
        if (int'(dut.count) > DEPTH) overflow = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset with rst already released.
    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; hold = 1'b0; redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input bit need_ack);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == addr && (imem_ack || !need_ack)) found = 1'b1;
            else tick();
        end
        check({tag, "_found"}, 32'(found), 32'd1);
    endtask

    task automatic expect_restart(input string tag, input logic [31:0] target,
                                  input logic [31:0] stale);
        bit got_req = 1'b0;
        bit got_out = 1'b0;
        for (int i = 0; i < 40 && !got_out; i++) begin
            if (!got_req && imem_req && imem_addr != stale) begin
                got_req = 1'b1;
                check({tag, "_req_addr"}, imem_addr, target);
            end
            if (id_valid) begin
                got_out = 1'b1;
                check({tag, "_inst"}, id_inst, target);
                check({tag, "_pc4"}, id_pc4, target + 32'd4);
            end else begin
                tick();
            end
        end
        check({tag, "_req_seen"}, 32'(got_req), 32'd1);
        check({tag, "_out_seen"}, 32'(got_out), 32'd1);
    endtask

    initial begin
        int ack_base;
        int n_r;
        int n_o;

        // Reset values, then zero-wait streaming.
        lat = 0;
        do_reset();
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_inst", id_inst, 32'd0);
        check("rst_pc4", id_pc4, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("stream_req", 32'(imem_req), 32'd1);
            check("stream_addr", imem_addr, 32'(4 * (c - 1)));
            check("stream_valid", 32'(id_valid), 32'(c >= 2));
            if (c >= 2) begin
                check("stream_inst", id_inst, 32'(4 * (c - 2)));
                check("stream_pc4", id_pc4, 32'(4 * (c - 1)));
            end
        end

        // Hold from reset: queue fills to DEPTH, then drains in order.
        lat = 0;
        do_reset();
        ack_base = n_acks;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) tick();
            hold = (c < 10);
            if (c < 10) check("hold_inst", id_inst, 32'd0);
            if (c == 5) check("hold_req_low", 32'(imem_req), 32'd0);
            if (c == 9) begin
                check("hold_acks", 32'(n_acks - ack_base), 32'd4);
                check("hold_req_end", 32'(imem_req), 32'd0);
                check("hold_valid", 32'(id_valid), 32'd1);
            end
            if (c >= 10) begin
                check("drain_valid", 32'(id_valid), 32'd1);
                check("drain_inst", id_inst, 32'(4 * (c - 10)));
                check("drain_pc4", id_pc4, 32'(4 * (c - 9)));
            end
            if (c == 11) begin
                check("resume_req", 32'(imem_req), 32'd1);
                check("resume_addr", imem_addr, 32'd16);
            end
        end

        // Latency 3, redirect one cycle after the request for 0x8 becomes visible.
        lat = 3;
        do_reset();
        wait_req("lat3_req8", 32'h8, 1'b0);
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("drop_req_held", 32'(imem_req), 32'd1);
        check("drop_addr_held", imem_addr, 32'h8);
        check("drop_valid", 32'(id_valid), 32'd0);
        expect_restart("drop", 32'h100, 32'h8);

        // Redirect in the same cycle as the ack for 0xC, with a valid head popping.
        lat = 0;
        do_reset();
        wait_req("ack_req_c", 32'hC, 1'b1);
        check("ackredir_pre_valid", 32'(id_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("ackredir_valid", 32'(id_valid), 32'd0);
        check("ackredir_req", 32'(imem_req), 32'd0);
        expect_restart("ackredir", 32'h40, 32'hC);

        // Address wrap across 2^32.
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        check("wrap_flush", 32'(id_valid), 32'd0);
        n_r = 0;
        n_o = 0;
        for (int i = 0; i < 30 && (n_r < 3 || n_o < 3); i++) begin
            if (imem_req && imem_ack && n_r < 3) begin
                check("wrap_addr", imem_addr, WRAP_A[n_r]);
                n_r++;
            end
            if (id_valid && n_o < 3) begin
                check("wrap_inst", id_inst, WRAP_A[n_o]);
                check("wrap_pc4", id_pc4, WRAP_P[n_o]);
                n_o++;
            end
            tick();
        end
        check("wrap_count", 32'(n_r + n_o), 32'd6);

        // Reset while WAITing with two entries queued and an ack in the reset cycle.
        lat = 0;
        do_reset();
        hold = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_pre_valid", 32'(id_valid), 32'd1);
        check("midrst_pre_addr", imem_addr, 32'h8);
        rst = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b0;
        check("midrst_valid", 32'(id_valid), 32'd0);
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        tick();
        check("midrst_first_req", 32'(imem_req), 32'd1);
        check("midrst_first_addr", imem_addr, 32'd0);
        tick();
        check("midrst_out_inst", id_inst, 32'd0);
        check("midrst_out_pc4", id_pc4, 32'd4);

        check("protocol_ack_without_req", 32'(proto_err), 32'd0);
        check("queue_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction-fetch front end with a small prefetch queue. Sits directly upstream of the pipeline's IF/ID register boundary.
- Issues sequential fetch requests to a variable-latency instruction memory over a req/ack handshake and buffers returned words.
- Presents one instruction plus its PC+4 per cycle to decode, honouring the decode hold (load-use stall).
- On a taken jump, discards all buffered and in-flight fetches and restarts at the jump target.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'd0, fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
redirect  input  1  taken jump; flush and restart fetch
redirect_pc  input  32  jump target, valid when redirect=1
hold  input  1  decode stall; head entry must not be consumed
id_valid  output  1  head entry valid toward decode
id_inst  output  32  head instruction word
id_pc4  output  32  fetch address of head instruction + 4
imem_req  output  1  fetch request, registered
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  response strobe, one cycle per request
imem_rdata  input  32  instruction word, valid with imem_ack

Behaviour:
- Reset values (cycle after rst=1): id_valid=0, id_inst=0, id_pc4=0, imem_req=0, imem_addr=RESET_PC, queue count=0, FSM=IDLE, fetch pc=RESET_PC. rst dominates every other input, including mid-request. A response acked in the rst cycle is dropped.
- Queue:
  - Circular, DEPTH entries of {inst, pc4}, wr/rd pointers with log2(DEPTH)+1-bit count.
  - No bypass. id_valid/id_inst/id_pc4 come from the registered head. id_inst/id_pc4 are don't-care when id_valid=0.
- Pop: id_valid=1 && hold=0 at a rising edge. Push: imem_ack=1 in state WAIT. Simultaneous push and pop keeps count unchanged.
- Credit rule: count + outstanding <= DEPTH always; outstanding is 0 or 1.
  - A request may start only if count (after this cycle's pop/push) + 1 <= DEPTH.
  - Overflow is impossible by construction. Bench asserts it.
- FSM:
  - IDLE: if credit available, assert imem_req with imem_addr=pc, go to WAIT.
  - WAIT: hold imem_req/imem_addr until imem_ack.
    - On ack: push {imem_rdata, imem_addr+4}, then pc=pc+4.
    - If credit remains, keep imem_req=1 with the new address next cycle (back-to-back, 1 fetch/cycle with a zero-wait memory). Otherwise drop imem_req and go to IDLE.
  - DROP: in-flight request is stale. Hold imem_req/imem_addr unchanged until imem_ack, discard the data, go to IDLE.
- Redirect (highest priority after rst):
  - Clears the queue (count=0, id_valid=0 next cycle); a same-cycle pop is ignored.
  - pc=redirect_pc.
  - FSM state change:
    - IDLE -> IDLE; new fetch begins the following cycle.
    - WAIT without ack -> DROP.
    - WAIT with ack in same cycle -> data discarded, IDLE.
    - DROP -> DROP, with pc updated to the newest target.
- Arithmetic: pc and pc4 are 32-bit unsigned, wrapping modulo 2^32 (0xFFFFFFFC + 4 = 0). redirect_pc low two bits are passed through unmodified.
- Latency: request issued in cycle N and acked in cycle N+k (k >= 0 cycles after req visible) gives id_valid=1 in cycle N+k+1.
- imem_ack while imem_req=0 is a protocol error. It is ignored; bench asserts it never occurs.

Test Plan:
- Reset release, zero-wait memory returning addr as data, hold=0:
  - imem_addr sequence 0,4,8,...
  - id_valid from cycle 2.
  - id_inst/id_pc4 = (0,4),(4,8),(8,12) on consecutive cycles.
- hold=1 for 10 cycles from reset:
  - exactly DEPTH=4 acks accepted; imem_req low after the 4th.
  - id_inst stays 0x0 throughout.
  - on hold release, 0,4,8,12 drain one per cycle, then fetch resumes at 16.
- Ack latency 3; redirect to 0x100 one cycle after a request to 0x8:
  - stale response for 0x8 never appears at id_inst.
  - next imem_addr=0x100 issued the cycle after that ack.
  - first post-redirect id_pc4=0x104.
- redirect to 0x40 in the same cycle as an ack for 0xC, with hold=0 and id_valid=1:
  - 0xC data discarded; queue empty next cycle.
  - next request addr=0x40.
- redirect_pc=0xFFFFFFF8:
  - fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - id_pc4 = 0xFFFFFFFC, 0x0, 0x4.
- rst asserted while in WAIT with 2 entries queued, ack arriving during rst:
  - next cycle id_valid=0, imem_req=0.
  - after release, first request addr=RESET_PC.
